herald_host_seq: RTL and testbench
==================================

# herald_host_seq

Host-side command sequencer directly upstream of the Herald accelerator port. It accepts a whole command word and operands from a parallel request interface, then serialises them onto Herald's byte bus: 8-bit data, WR/RD edge-triggered strobes and BUSY on data-out bit 7. It polls BUSY, reads back the result bytes LSB-first and presents the assembled result with a one-cycle `done` pulse. It is used as the on-chip/FPGA driver for Herald and as the bus-functional master in the Herald benches.

## Interface
- `STROBE_W`, default 2: cycles each WR/RD strobe is held high (≥1).
- `GAP_W`, default 2: cycles strobe is held low after each high phase (≥2).
- `RD_LAT`, default 2: cycles from RD rising to capture of `bus_din` (1 ≤ RD_LAT < STROBE_W+GAP_W).
- `TIMEOUT`, default 4095: max BUSY-poll cycles before abort (12-bit counter).
- `clk` in 1: single clock for the block and Herald.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe, sampled only when `busy`=0.
- `cmd` in 8: Herald command code (0x10, 0x11, 0x12, 0x20, 0x21, 0x22).
- `op_a` in 32: operand A.
- `op_b` in 32: operand B.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: bad command or timeout; valid with `done`, held until next accepted start.
- `result` out 64: assembled result; upper 32 bits zero for 4-byte results; held until next accepted start.
- `bus_dout` out 8: to Herald `ui_in`.
- `bus_wr` out 1: to Herald `uio_in[0]`.
- `bus_rd` out 1: to Herald `uio_in[1]`.
- `bus_din` in 8: from Herald `uo_out`.

## Operation
- States: IDLE, WR_HI, WR_LO, POLL, RD_HI, RD_LO, FIN.
- IDLE: on `start`, latch cmd/op_a/op_b, clear `err` and `result`, set `busy`.
  - Unsupported cmd: go to FIN with `err`=1. No bus activity.
  - Otherwise: byte index 0, go to WR_HI.
- Write byte list:
  - 0x22: cmd only, 1 byte.
  - 0x10: cmd, op_a[7:0] .. op_a[31:24], 5 bytes.
  - 0x11/0x12/0x20/0x21: cmd, op_a LSB-first, then op_b LSB-first, 9 bytes.
- WR_HI: `bus_wr`=1 for STROBE_W cycles. WR_LO: `bus_wr`=0 for GAP_W cycles. `bus_dout` carries the current byte through both phases. Advance the index after WR_LO. After the last byte, go to POLL with `bus_dout`=0.
- POLL: sample `bus_din[7]` each cycle, count cycles.
  - Bit 7 = 0: go to RD_HI (result bytes > 0) or FIN (0x22).
  - Count reaches TIMEOUT: go to FIN with `err`=1 and `result`=0.
- Read byte count: 8 for 0x10; 4 for 0x11, 0x12, 0x20, 0x21; 0 for 0x22.
- RD_HI: `bus_rd`=1 for STROBE_W cycles. RD_LO: `bus_rd`=0 for GAP_W cycles.
  - Capture `bus_din` into `result[8*i+7:8*i]` exactly RD_LAT cycles after the cycle `bus_rd` first went high. The capture counter spans RD_HI and RD_LO.
  - After the last RD_LO, go to FIN.
- FIN: `done`=1 for one cycle, `busy`=0 in the same cycle, return to IDLE.
- `start` while `busy`=1: ignored, not queued.
- `start` in the FIN cycle: ignored. Earliest accepted start is the cycle after FIN.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `result`=0, `bus_dout`=0, `bus_wr`=0, `bus_rd`=0, state IDLE, all counters 0.
- `start` sampled at edge E: `busy`=1, `bus_wr`=1 and `bus_dout`=cmd are visible after E.
- Each byte occupies P = STROBE_W+GAP_W cycles.
- With defaults (P=4):
  - 0x10: 20 write cycles + poll + 32 read cycles + 1 FIN cycle.
  - Bad cmd: `done` is high in the cycle after start acceptance.
- Poll counter starts at 0 on POLL entry. `err` asserts after TIMEOUT consecutive cycles with bit 7 = 1.
- Reset mid-transaction: all outputs return to reset values at the next edge. No partial `done` is issued. Herald must be reset in the same cycle.

## Test plan
- 0x10, op_a=0x0000C000, responder returns 0x1122334455667788 → bus sees 10,00,C0,00,00 with strobes 2 high/2 low; `result`=0x1122334455667788, `err`=0, single `done`.
- 0x20, op_a=0x00030000, op_b=0x00020000, BUSY held for 7 cycles, responder returns 0x00060000 → 9 write bytes in order; `result`=0x0000000000060000.
- 0x22 → exactly one WR strobe, `bus_rd` never asserted, `done` with `result`=0.
- cmd=0x33 → no `bus_wr`/`bus_rd` activity, `done`+`err`=1 in the cycle after start.
- BUSY stuck at 1 with TIMEOUT=16 → `done`+`err`=1 after 16 poll cycles, `result`=0. Then a second `start` during the sequence is ignored and `rst` mid-write zeroes all outputs on the next edge.

Source files
------------

// File: rtl/herald_host_seq.sv
// herald_host_seq: host-side command sequencer for the Herald accelerator.
// Takes a command word and two operands in parallel, writes them to Herald
// byte by byte with WR strobes, polls BUSY on bus_din[7], reads the result
// back LSB-first with RD strobes and reports it with a one-cycle done pulse.
module herald_host_seq #(
   parameter int STROBE_W = 2,    // cycles each strobe is held high
   parameter int GAP_W    = 2,    // cycles strobe is held low after each high phase
   parameter int RD_LAT   = 2,    // cycles from RD rising to capture of bus_din
   parameter int TIMEOUT  = 4095  // BUSY-poll cycles before abort
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  cmd,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [63:0] result,
   output logic [7:0]  bus_dout,
   output logic        bus_wr,
   output logic        bus_rd,
   input  logic [7:0]  bus_din
);

   localparam int P     = STROBE_W + GAP_W;
   localparam int CYC_W = (P > 1) ? $clog2(P) : 1;

   // Phase-counter values that end the high phase, end the byte slot,
   // and mark the read capture point.
   localparam logic [CYC_W-1:0] HI_LAST   = CYC_W'(STROBE_W - 1);
   localparam logic [CYC_W-1:0] SLOT_LAST = CYC_W'(P - 1);
   localparam logic [CYC_W-1:0] CAP_AT    = CYC_W'(RD_LAT - 1);
   localparam logic [11:0]      POLL_LAST = 12'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_HI,
      S_WR_LO,
      S_POLL,
      S_RD_HI,
      S_RD_LO,
      S_FIN
   } state_t;

   // Number of bytes written for a command; zero marks an unsupported code.
   function automatic logic [3:0] wr_count(input logic [7:0] c);
      case (c)
         8'h22:                      wr_count = 4'd1;
         8'h10:                      wr_count = 4'd5;
         8'h11, 8'h12, 8'h20, 8'h21: wr_count = 4'd9;
         default:                    wr_count = 4'd0;
      endcase
   endfunction

   // Number of result bytes read back for a command.
   function automatic logic [3:0] rd_count(input logic [7:0] c);
      case (c)
         8'h10:                      rd_count = 4'd8;
         8'h11, 8'h12, 8'h20, 8'h21: rd_count = 4'd4;
         default:                    rd_count = 4'd0;
      endcase
   endfunction

   state_t           state;
   logic [63:0]      op_sr;     // operand bytes still to be written, LSB next
   logic [3:0]       byte_idx;  // current byte within the write or read list
   logic [3:0]       wr_last;   // index of the final write byte
   logic [3:0]       rd_cnt;    // result bytes to read for this command
   logic [CYC_W-1:0] cyc;       // position inside the current byte slot
   logic [11:0]      poll_cnt;  // consecutive BUSY-high poll cycles
   logic [3:0]       req_wr;
   logic [3:0]       req_rd;

   assign req_wr = wr_count(cmd);
   assign req_rd = rd_count(cmd);

   // Sequencer FSM: every output is a register updated alongside the state.
   // NOTE: all state and outputs use non-blocking assignments so every branch
   // sees the values from before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
         bus_dout <= '0;
         bus_wr   <= 1'b0;
         bus_rd   <= 1'b0;
         op_sr    <= '0;
         byte_idx <= '0;
         wr_last  <= '0;
         rd_cnt   <= '0;
         cyc      <= '0;
         poll_cnt <= '0;
      end else begin
         done <= 1'b0;

         // The capture point is counted from RD rising and may land in either phase.
         if ((state == S_RD_HI || state == S_RD_LO) && cyc == CAP_AT)
            result[{byte_idx[2:0], 3'b000} +: 8] <= bus_din;

         case (state)
            S_IDLE: begin
               if (start) begin
                  err    <= 1'b0;
                  result <= '0;
                  if (req_wr == 4'd0) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     busy     <= 1'b1;
                     bus_wr   <= 1'b1;
                     bus_dout <= cmd;
                     op_sr    <= {op_b, op_a};
                     byte_idx <= '0;
                     cyc      <= '0;
                     wr_last  <= req_wr - 4'd1;
                     rd_cnt   <= req_rd;
                     state    <= S_WR_HI;
                  end
               end
            end

            S_WR_HI: begin
               cyc <= cyc + 1'b1;
               if (cyc == HI_LAST) begin
                  bus_wr <= 1'b0;
                  state  <= S_WR_LO;
               end
            end

            S_WR_LO: begin
               if (cyc == SLOT_LAST) begin
                  cyc <= '0;
                  if (byte_idx == wr_last) begin
                     bus_dout <= '0;
                     poll_cnt <= '0;
                     state    <= S_POLL;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     bus_dout <= op_sr[7:0];
                     op_sr    <= op_sr >> 8;
                     bus_wr   <= 1'b1;
                     state    <= S_WR_HI;
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end

            S_POLL: begin
               if (!bus_din[7]) begin
                  if (rd_cnt == 4'd0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     bus_rd   <= 1'b1;
                     byte_idx <= '0;
                     cyc      <= '0;
                     state    <= S_RD_HI;
                  end
               end else if (poll_cnt == POLL_LAST) begin
                  err    <= 1'b1;
                  result <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_FIN;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
            end

            S_RD_HI: begin
               cyc <= cyc + 1'b1;
               if (cyc == HI_LAST) begin
                  bus_rd <= 1'b0;
                  state  <= S_RD_LO;
               end
            end

            S_RD_LO: begin
               if (cyc == SLOT_LAST) begin
                  cyc <= '0;
                  if (byte_idx == rd_cnt - 4'd1) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     bus_rd   <= 1'b1;
                     state    <= S_RD_HI;
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end

            // done is high for this one cycle; start is not looked at here.
            S_FIN: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_herald_host_seq.sv
// Bench for herald_host_seq: a Herald responder model drives bus_din, a
// scoreboard holds expected write bytes, read bytes and results.
module tb_herald_host_seq;

   localparam int STROBE_W = 2;
   localparam int GAP_W    = 2;
   localparam int RD_LAT   = 2;
   localparam int TIMEOUT  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cmd;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] result;
   logic [7:0]  bus_dout;
   logic        bus_wr;
   logic        bus_rd;
   logic [7:0]  bus_din = 8'h00;

   int total = 0;
   int bad   = 0;

   // Scoreboard queues.
   logic [7:0]  exp_wr_q[$];
   logic [7:0]  rd_q[$];
   logic [63:0] exp_res_q[$];
   logic        exp_err_q[$];

   // Responder / monitor state.
   int   cfg_busy  = 0;
   bit   stuck     = 1'b0;
   int   busy_left = 0;
   logic wr_prev   = 1'b0;
   logic rd_prev   = 1'b0;
   int   wr_hi_len = 0;
   int   rd_hi_len = 0;
   int   wr_rises  = 0;
   int   rd_rises  = 0;
   int   done_cnt  = 0;
   int   w0, r0, d0, lat;

   always #5 clk = ~clk;

   herald_host_seq #(
      .STROBE_W(STROBE_W),
      .GAP_W   (GAP_W),
      .RD_LAT  (RD_LAT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .cmd     (cmd),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result),
      .bus_dout(bus_dout),
      .bus_wr  (bus_wr),
      .bus_rd  (bus_rd),
      .bus_din (bus_din)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Responder and monitor, evaluated on the falling edge away from DUT updates.
   always @(negedge clk) begin
      if (rst) begin
         wr_prev   = 1'b0;
         rd_prev   = 1'b0;
         wr_hi_len = 0;
         rd_hi_len = 0;
         busy_left = 0;
         bus_din   = 8'h00;
      end else begin
         if (bus_wr) begin
            if (!wr_prev) begin
               wr_rises++;
               if (exp_wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
               else check("wr_byte", 64'(bus_dout), 64'(exp_wr_q.pop_front()));
               bus_din = 8'h80;
               if (exp_wr_q.size() == 0) busy_left = cfg_busy + STROBE_W + GAP_W;
            end else if (busy_left > 0) begin
               busy_left--;
            end
            wr_hi_len++;
         end else begin
            if (wr_prev) begin
               check("wr_high_len", 64'(wr_hi_len), 64'(STROBE_W));
               wr_hi_len = 0;
            end
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0 && !stuck) bus_din = 8'h00;
            end
         end

         if (bus_rd) begin
            if (!rd_prev) begin
               rd_rises++;
               if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
               else bus_din = rd_q.pop_front();
            end
            rd_hi_len++;
         end else if (rd_prev) begin
            check("rd_high_len", 64'(rd_hi_len), 64'(STROBE_W));
            rd_hi_len = 0;
         end

         if (done) begin
            done_cnt++;
            check("busy_at_done", 64'(busy), 64'd0);
            if (exp_res_q.size() == 0) begin
               check("done_unexpected", 64'd1, 64'd0);
            end else begin
               check("result", result, exp_res_q.pop_front());
               check("err", 64'(err), 64'(exp_err_q.pop_front()));
            end
         end

         wr_prev = bus_wr;
         rd_prev = bus_rd;
      end
   end

   // Queue the bytes Herald should see for a command.
   task automatic push_wr(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b, input int n);
      logic [63:0] ops;
      ops = {b, a};
      exp_wr_q.push_back(c);
      for (int i = 0; i < n - 1; i++) exp_wr_q.push_back(ops[8*i +: 8]);
   endtask

   task automatic push_rd(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) rd_q.push_back(v[8*i +: 8]);
   endtask

   task automatic snap();
      w0 = wr_rises;
      r0 = rd_rises;
      d0 = done_cnt;
   endtask

   task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
      cmd   = c;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count falling edges until done is seen, bounded by max.
   task automatic run_until_done(input string tag, input int max, output int cyc);
      int d_start;
      d_start = done_cnt;
      cyc = 0;
      while (done_cnt == d_start && cyc < max) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      if (done_cnt == d_start) check({tag, "_no_done"}, 64'd1, 64'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      cmd   = '0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_dout", 64'(bus_dout), 64'd0);
      check("rst_wr", 64'(bus_wr), 64'd0);
      check("rst_rd", 64'(bus_rd), 64'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;

      // 0x10 with an immediate BUSY release, 8-byte result.
      cfg_busy = 0;
      push_wr(8'h10, 32'h0000_C000, 32'h0, 5);
      push_rd(64'h1122_3344_5566_7788, 8);
      exp_res_q.push_back(64'h1122_3344_5566_7788);
      exp_err_q.push_back(1'b0);
      snap();
      issue(8'h10, 32'h0000_C000, 32'hDEAD_BEEF);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_wr", 64'(bus_wr), 64'd1);
      check("t1_dout", 64'(bus_dout), 64'h10);
      run_until_done("t1", 200, lat);
      check("t1_latency", 64'(lat), 64'd54);
      repeat (4) @(negedge clk);
      #1;
      check("t1_one_done", 64'(done_cnt - d0), 64'd1);
      check("t1_wr_count", 64'(wr_rises - w0), 64'd5);
      check("t1_rd_count", 64'(rd_rises - r0), 64'd8);
      check("t1_hold", result, 64'h1122_3344_5566_7788);

      // Unsupported command; start held through the FIN cycle must not restart.
      exp_res_q.push_back(64'h0);
      exp_err_q.push_back(1'b1);
      snap();
      cmd   = 8'h33;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("bad_done", 64'(done), 64'd1);
      check("bad_err", 64'(err), 64'd1);
      check("bad_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("bad_one_done", 64'(done_cnt - d0), 64'd1);
      check("bad_wr_count", 64'(wr_rises - w0), 64'd0);
      check("bad_rd_count", 64'(rd_rises - r0), 64'd0);
      check("bad_err_hold", 64'(err), 64'd1);

      // 0x20 with BUSY held 7 poll cycles; a start mid-sequence is ignored.
      cfg_busy = 7;
      push_wr(8'h20, 32'h0003_0000, 32'h0002_0000, 9);
      push_rd(64'h0006_0000, 4);
      exp_res_q.push_back(64'h0000_0000_0006_0000);
      exp_err_q.push_back(1'b0);
      snap();
      issue(8'h20, 32'h0003_0000, 32'h0002_0000);
      repeat (10) @(negedge clk);
      #1;
      issue(8'h33, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_until_done("t2", 200, lat);
      check("t2_latency", 64'(lat + 10), 64'd61);
      repeat (3) @(negedge clk);
      #1;
      check("t2_one_done", 64'(done_cnt - d0), 64'd1);
      check("t2_wr_count", 64'(wr_rises - w0), 64'd9);
      check("t2_rd_count", 64'(rd_rises - r0), 64'd4);

      // 0x22: single write, no read, previous result cleared.
      cfg_busy = 3;
      push_wr(8'h22, 32'h0, 32'h0, 1);
      exp_res_q.push_back(64'h0);
      exp_err_q.push_back(1'b0);
      snap();
      issue(8'h22, 32'h1234_5678, 32'h9ABC_DEF0);
      run_until_done("t3", 100, lat);
      check("t3_latency", 64'(lat), 64'd9);
      repeat (3) @(negedge clk);
      #1;
      check("t3_wr_count", 64'(wr_rises - w0), 64'd1);
      check("t3_rd_count", 64'(rd_rises - r0), 64'd0);

      // BUSY stuck high: abort after TIMEOUT poll cycles.
      stuck = 1'b1;
      push_wr(8'h11, 32'h0000_0001, 32'h0000_0002, 9);
      exp_res_q.push_back(64'h0);
      exp_err_q.push_back(1'b1);
      snap();
      issue(8'h11, 32'h0000_0001, 32'h0000_0002);
      run_until_done("t5", 200, lat);
      check("t5_latency", 64'(lat), 64'd53);
      check("t5_rd_count", 64'(rd_rises - r0), 64'd0);
      stuck = 1'b0;
      repeat (2) @(negedge clk);
      #1;

      // Reset in the middle of the write phase.
      push_wr(8'h21, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 9);
      snap();
      issue(8'h21, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      repeat (5) @(negedge clk);
      #1;
      check("mid_wr_active", 64'(bus_wr), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      check("mid_rst_result", result, 64'd0);
      check("mid_rst_dout", 64'(bus_dout), 64'd0);
      check("mid_rst_wr", 64'(bus_wr), 64'd0);
      check("mid_rst_rd", 64'(bus_rd), 64'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      exp_wr_q.delete();
      rd_q.delete();
      snap();
      repeat (12) @(negedge clk);
      #1;
      check("mid_no_done", 64'(done_cnt - d0), 64'd0);
      check("mid_no_wr", 64'(wr_rises - w0), 64'd0);

      // Normal operation resumes after reset.
      cfg_busy = 3;
      push_wr(8'h22, 32'h0, 32'h0, 1);
      exp_res_q.push_back(64'h0);
      exp_err_q.push_back(1'b0);
      snap();
      issue(8'h22, 32'h0, 32'h0);
      run_until_done("t7", 100, lat);
      check("t7_latency", 64'(lat), 64'd9);
      repeat (2) @(negedge clk);
      #1;
      check("sb_wr_empty", 64'(exp_wr_q.size()), 64'd0);
      check("sb_res_empty", 64'(exp_res_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
